// File: rtl/vme_mem_master.sv
// rtl/vme_mem_master.sv - single-outstanding VME memory-strobe initiator
// One read or write at a time: one-cycle strobe, wait for the matching done or a timeout.
module vme_mem_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  Clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH-1:0] VMEAddr,
  output logic [DATA_WIDTH-1:0] VMEWrData,
  output logic                  VMERdMem,
  output logic                  VMEWrMem,
  input  logic [DATA_WIDTH-1:0] VMERdData,
  input  logic                  VMERdDone,
  input  logic                  VMEWrDone
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  rd_stb_q, rd_stb_d;
  logic                  wr_stb_q, wr_stb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rd_stb_d = 1'b0;
    wr_stb_d = 1'b0;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    // busy stays up through the ack cycle, so a request there is refused
    if (ack_q) busy_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i && !busy_q) begin
          addr_d   = addr_i;
          wdata_d  = wdata_i;
          rd_stb_d = !we_i;
          wr_stb_d = we_i;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = we_i ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (VMERdDone) begin
          state_d = IDLE;
          ack_d   = 1'b1;
          rdata_d = VMERdData;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          rdata_d = '1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WR_WAIT: begin
        if (VMEWrDone) begin
          state_d = IDLE;
          ack_d   = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = busy_q;
  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign VMEAddr   = addr_q;
  assign VMEWrData = wdata_q;
  assign VMERdMem  = rd_stb_q;
  assign VMEWrMem  = wr_stb_q;

endmodule

// File: tb/tb_vme_mem_master.sv
// tb/tb_vme_mem_master.sv - randomized transaction-level check of vme_mem_master
// Expected ack cycle, status and read data are derived per transaction from the done delay.
module tb_vme_mem_master;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          Clk = 1'b0;
  logic          rst_n;
  logic          req_i, we_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wdata_i;
  logic          busy_o, ack_o, err_o;
  logic [DW-1:0] rdata_o;
  logic [AW-1:0] VMEAddr;
  logic [DW-1:0] VMEWrData;
  logic          VMERdMem, VMEWrMem;
  logic [DW-1:0] VMERdData;
  logic          VMERdDone, VMEWrDone;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_rdata;

  always #5 Clk = ~Clk;

  vme_mem_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .Clk(Clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .ack_o(ack_o), .err_o(err_o),
    .rdata_o(rdata_o), .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
    .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem), .VMERdData(VMERdData),
    .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // k = cycles from strobe to matching done; k > TMO means the done arrives too late
  task automatic run_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int k, input logic [DW-1:0] rv, input bit noise);
    bit            terr;
    int            ea;
    logic [DW-1:0] cap;
    logic [DW-1:0] rd;
    terr = (k > TMO);
    ea   = 2 + (terr ? TMO : k);
    cap  = '1;
    @(negedge Clk);
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d;
    VMERdDone = 1'b0; VMEWrDone = 1'b0;
    for (int c = 1; c <= ea + 2; c++) begin
      @(negedge Clk);
      if (c == ea && !we) exp_rdata = terr ? '1 : cap;
      check_eq("rd_strobe", VMERdMem, (c == 1) && !we);
      check_eq("wr_strobe", VMEWrMem, (c == 1) && we);
      check_eq("addr_hold", VMEAddr, a);
      check_eq("wdata_hold", VMEWrData, d);
      check_eq("busy", busy_o, c <= ea);
      check_eq("ack", ack_o, c == ea);
      check_eq("rdata", rdata_o, exp_rdata);
      if (c == ea) check_eq("err", err_o, terr);
      req_i   = (noise && c <= ea) ? 1'($urandom_range(0, 1)) : 1'b0;
      we_i    = 1'($urandom_range(0, 1));
      addr_i  = AW'($urandom);
      wdata_i = $urandom;
      rd      = (c == 1 + k) ? rv : $urandom;
      VMERdData = rd;
      if (c == 1 + k && !terr) cap = rd;
      if (c == 1 + k) begin
        VMERdDone = !we; VMEWrDone = we;
      end else if (c >= ea && noise) begin
        VMERdDone = 1'($urandom_range(0, 1)); VMEWrDone = 1'($urandom_range(0, 1));
      end else begin
        VMERdDone = we ? (noise && 1'($urandom_range(0, 1))) : 1'b0;
        VMEWrDone = we ? 1'b0 : (noise && 1'($urandom_range(0, 1)));
      end
      if (c > ea) begin
        VMERdDone = (c == ea + 1) && terr && !we;
        VMEWrDone = (c == ea + 1) && terr && we;
      end
    end
    req_i = 1'b0; VMERdDone = 1'b0; VMEWrDone = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      check_eq("idle_ack", ack_o, 1'b0);
      check_eq("idle_busy", busy_o, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    VMERdData = '0; VMERdDone = 1'b0; VMEWrDone = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_ack", ack_o, 1'b0);
    check_eq("rst_err", err_o, 1'b0);
    check_eq("rst_rdmem", VMERdMem, 1'b0);
    check_eq("rst_wrmem", VMEWrMem, 1'b0);
    check_eq("rst_rdata", rdata_o, '0);
    check_eq("rst_addr", VMEAddr, '0);
    check_eq("rst_wdata", VMEWrData, '0);
    exp_rdata = '0;
    rst_n = 1'b1;

    run_txn(1'b0, 8'h10, 32'h0, 1, 32'h0000_00A5, 1'b0);
    check_eq("read_a5", rdata_o, 32'h0000_00A5);
    run_txn(1'b1, 8'h04, 32'hDEAD_BEEF, 2, 32'h1234_5678, 1'b0);
    run_txn(1'b0, 8'h22, 32'h0, TMO + 2, 32'h5555_5555, 1'b0);
    run_txn(1'b0, 8'h23, 32'h0, TMO, 32'h0BAD_F00D, 1'b0);
    run_txn(1'b1, 8'h31, 32'hCAFE_0001, 3, 32'h0, 1'b1);
    run_txn(1'b1, 8'h32, 32'hCAFE_0002, 0, 32'h0, 1'b1);

    // reset lands in cycle 2 of a read
    @(negedge Clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 8'h77;
    @(negedge Clk);
    req_i = 1'b0;
    check_eq("pre_rst_strobe", VMERdMem, 1'b1);
    @(negedge Clk);
    rst_n = 1'b0;
    @(negedge Clk);
    rst_n = 1'b1;
    exp_rdata = '0;
    check_eq("mid_rst_rdmem", VMERdMem, 1'b0);
    check_eq("mid_rst_busy", busy_o, 1'b0);
    check_eq("mid_rst_ack", ack_o, 1'b0);
    check_eq("mid_rst_addr", VMEAddr, '0);
    check_eq("mid_rst_rdata", rdata_o, '0);
    idle_gap(TMO + 3);
    run_txn(1'b0, 8'h78, 32'h0, 2, 32'h600D_0001, 1'b0);

    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom,
              $urandom_range(0, TMO + 2), $urandom, 1'b1);
      idle_gap($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
